// File: rtl/datapath_seq_if.sv
// Request, completion, bus-observation and debug-read signals of datapath_seq.
// master = requester/observer side, slave = the datapath itself.
interface datapath_seq_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
);
    logic              start;
    logic              cmd_load;
    logic [3:0]        op;
    logic [SEL_W-1:0]  ra;
    logic [SEL_W-1:0]  rb;
    logic [SEL_W-1:0]  rd;
    logic [DATA_W-1:0] din;
    logic              ready;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] bus;
    logic [SEL_W-1:0]  dbg_sel;
    logic [DATA_W-1:0] dbg_data;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, cmd_load, op, ra, rb, rd, din, dbg_sel,
        input  ready, done, err, bus, dbg_data, hi, lo
    );

    modport slave (
        input  start, cmd_load, op, ra, rb, rd, din, dbg_sel,
        output ready, done, err, bus, dbg_data, hi, lo
    );
endinterface

// File: rtl/datapath_seq.sv
// Single-bus register datapath with a micro-sequencer: rd <- ra op rb (4 cycles, MUL 5) or rd <- din (2 cycles).
// start is only accepted while ready (IDLE); start during a sequence is dropped, never queued.
module datapath_seq #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = 4
) (
    input logic           clock,
    input logic           clear,
    datapath_seq_if.slave dp
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [SEL_W:0] NREGS = (SEL_W+1)'(NUM_REGS);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    typedef enum logic [2:0] {S_IDLE, S_LDA, S_EXE, S_WBL, S_WBH, S_MWB} state_t;

    state_t              state_q;
    logic                load_q;
    logic [3:0]          op_q;
    logic [SEL_W-1:0]    ra_q;
    logic [SEL_W-1:0]    rb_q;
    logic [SEL_W-1:0]    rd_q;
    logic                err_pend_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   y_q;
    logic [DATA_W-1:0]   zlo_q;
    logic [DATA_W-1:0]   zhi_q;
    logic [DATA_W-1:0]   mdr_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic [DATA_W-1:0]   src_a;
    logic [DATA_W-1:0]   src_b;
    logic [DATA_W-1:0]   bus_d;
    logic [DATA_W-1:0]   zlo_d;
    logic [DATA_W-1:0]   zhi_d;
    logic [DATA_W-1:0]   dbg_d;
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod;
    logic                acc_err;

    function automatic logic in_range(input logic [SEL_W-1:0] sel);
        return ({1'b0, sel} < NREGS);
    endfunction

    // Out-of-range selects read as zero, both on the bus and on the debug port.
    always_comb begin
        src_a = '0;
        src_b = '0;
        dbg_d = '0;
        if (in_range(ra_q))       src_a = regs_q[IDX_W'(ra_q)];
        if (in_range(rb_q))       src_b = regs_q[IDX_W'(rb_q)];
        if (in_range(dp.dbg_sel)) dbg_d = regs_q[IDX_W'(dp.dbg_sel)];
    end

    // Exactly one bus source per state.
    always_comb begin
        bus_d = '0;
        case (state_q)
            S_LDA:   bus_d = src_a;
            S_EXE:   bus_d = src_b;
            S_WBL:   bus_d = zlo_q;
            S_WBH:   bus_d = zhi_q;
            S_MWB:   bus_d = mdr_q;
            default: bus_d = '0;
        endcase
    end

    // Sign-extended operands make the low 2*DATA_W bits of the product the signed result.
    assign a_ext = {{DATA_W{y_q[DATA_W-1]}}, y_q};
    assign b_ext = {{DATA_W{bus_d[DATA_W-1]}}, bus_d};
    assign prod  = a_ext * b_ext;

    always_comb begin
        zlo_d = '0;
        zhi_d = '0;
        case (op_q)
            OP_ADD: zlo_d = y_q + bus_d;
            OP_SUB: zlo_d = y_q - bus_d;
            OP_AND: zlo_d = y_q & bus_d;
            OP_OR:  zlo_d = y_q | bus_d;
            OP_XOR: zlo_d = y_q ^ bus_d;
            OP_SHL: zlo_d = y_q << bus_d[SH_W-1:0];
            OP_SHR: zlo_d = y_q >> bus_d[SH_W-1:0];
            OP_MUL: begin
                zlo_d = prod[DATA_W-1:0];
                zhi_d = prod[2*DATA_W-1:DATA_W];
            end
            default: begin
                zlo_d = '0;
                zhi_d = '0;
            end
        endcase
    end

    // Loads only use rd; ALU ops flag reserved opcodes and any bad select.
    always_comb begin
        if (dp.cmd_load) begin
            acc_err = !in_range(dp.rd);
        end else begin
            acc_err = dp.op[3] | !in_range(dp.ra) | !in_range(dp.rb) | !in_range(dp.rd);
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= S_IDLE;
            load_q     <= 1'b0;
            op_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            rd_q       <= '0;
            err_pend_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            y_q        <= '0;
            zlo_q      <= '0;
            zhi_q      <= '0;
            mdr_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dp.start) begin
                        load_q     <= dp.cmd_load;
                        op_q       <= dp.op;
                        ra_q       <= dp.ra;
                        rb_q       <= dp.rb;
                        rd_q       <= dp.rd;
                        err_pend_q <= acc_err;
                        if (dp.cmd_load) begin
                            mdr_q   <= dp.din;
                            state_q <= S_MWB;
                        end else begin
                            state_q <= S_LDA;
                        end
                    end
                end
                S_LDA: begin
                    y_q     <= bus_d;
                    state_q <= S_EXE;
                end
                S_EXE: begin
                    zlo_q   <= zlo_d;
                    zhi_q   <= zhi_d;
                    state_q <= S_WBL;
                end
                S_WBL: begin
                    if (op_q == OP_MUL) begin
                        lo_q    <= bus_d;
                        state_q <= S_WBH;
                    end else begin
                        if (in_range(rd_q)) regs_q[IDX_W'(rd_q)] <= bus_d;
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        err_q   <= err_pend_q;
                    end
                end
                S_WBH: begin
                    hi_q    <= bus_d;
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                    err_q   <= err_pend_q;
                end
                S_MWB: begin
                    if (in_range(rd_q)) regs_q[IDX_W'(rd_q)] <= bus_d;
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                    err_q   <= err_pend_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dp.ready    = (state_q == S_IDLE);
    assign dp.done     = done_q;
    assign dp.err      = err_q;
    assign dp.bus      = bus_d;
    assign dp.dbg_data = dbg_d;
    assign dp.hi       = hi_q;
    assign dp.lo       = lo_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: a register/HI/LO model pushes expected results at issue time,
// and each completion pops one entry and checks latency, err, register file, HI and LO.
module tb_datapath_seq;
    localparam int NR = 12;

    typedef struct {
        logic [3:0]  d;
        logic        chk;
        logic [31:0] val;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          lat;
    } exp_t;

    logic clock;
    logic clear;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_done_cyc = 0;

    exp_t        exp_q[$];
    int          acc_q[$];
    logic [31:0] mdl [16];
    logic [31:0] mhi;
    logic [31:0] mlo;

    datapath_seq_if #(.DATA_W(32), .SEL_W(4)) dp ();

    datapath_seq #(.DATA_W(32), .NUM_REGS(NR), .SEL_W(4)) dut (
        .clock (clock),
        .clear (clear),
        .dp    (dp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        mhi = 32'h0;
        mlo = 32'h0;
    endfunction

    function automatic void model_push(input logic ld, input logic [3:0] o, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] d, input logic [31:0] data);
        exp_t        e;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] res;
        longint      p;
        va  = (a < NR) ? mdl[a] : 32'h0;
        vb  = (b < NR) ? mdl[b] : 32'h0;
        res = 32'h0;
        p   = 0;
        if (ld) res = data;
        else begin
            case (o)
                4'd0: res = va + vb;
                4'd1: res = va - vb;
                4'd2: res = va & vb;
                4'd3: res = va | vb;
                4'd4: res = va ^ vb;
                4'd5: res = va << vb[4:0];
                4'd6: res = va >> vb[4:0];
                4'd7: p = longint'($signed(va)) * longint'($signed(vb));
                default: res = 32'h0;
            endcase
        end
        if (!ld && o == 4'd7) begin
            mlo = p[31:0];
            mhi = p[63:32];
        end else if (d < NR) begin
            mdl[d] = res;
        end
        e.d   = d;
        e.chk = (d < NR);
        e.val = mdl[d];
        e.hi  = mhi;
        e.lo  = mlo;
        e.err = ld ? (d >= NR) : (o >= 8 || a >= NR || b >= NR || d >= NR);
        e.lat = ld ? 2 : ((o == 4'd7) ? 5 : 4);
        exp_q.push_back(e);
    endfunction

    task automatic issue(input bit now, input logic ld, input logic [3:0] o, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] d, input logic [31:0] data);
        if (!now) begin
            @(posedge clock);
            #1;
        end
        dp.cmd_load = ld;
        dp.op       = o;
        dp.ra       = a;
        dp.rb       = b;
        dp.rd       = d;
        dp.din      = data;
        dp.start    = 1'b1;
        model_push(ld, o, a, b, d, data);
        @(posedge clock);
        #1;
        acc_q.push_back(cyc);
        dp.start    = 1'b0;
        dp.cmd_load = 1'($urandom);
        dp.op       = 4'($urandom);
        dp.ra       = 4'($urandom);
        dp.rb       = 4'($urandom);
        dp.rd       = 4'($urandom);
        dp.din      = $urandom;
    endtask

    task automatic wait_done();
        int   n;
        int   a;
        exp_t e;
        n = 0;
        forever begin
            @(negedge clock);
            n++;
            if (dp.done === 1'b1 || n >= 40) break;
            checks++;
            if (dp.err !== 1'b0) begin
                errors++;
                $display("FAIL err_early: err=%b while done low", dp.err);
            end
        end
        checks++;
        if (dp.done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", dp.done, n);
            exp_q.delete();
            acc_q.delete();
            return;
        end
        last_done_cyc = cyc;
        checks++;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_done: done with %0d expected entries outstanding", exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        checks++;
        if (cyc - a + 1 != e.lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d", cyc - a + 1, e.lat);
        end
        checks++;
        if (dp.err !== e.err) begin
            errors++;
            $display("FAIL err_with_done: got %b expected %b", dp.err, e.err);
        end
        checks++;
        if (dp.ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_with_done: got %b expected 1", dp.ready);
        end
        checks++;
        if (dp.lo !== e.lo) begin
            errors++;
            $display("FAIL lo: got %h expected %h", dp.lo, e.lo);
        end
        checks++;
        if (dp.hi !== e.hi) begin
            errors++;
            $display("FAIL hi: got %h expected %h", dp.hi, e.hi);
        end
        if (e.chk) begin
            dp.dbg_sel = e.d;
            #1;
            checks++;
            if (dp.dbg_data !== e.val) begin
                errors++;
                $display("FAIL reg_R%0d: got %h expected %h", e.d, dp.dbg_data, e.val);
            end
        end
        @(negedge clock);
        checks++;
        if (dp.done !== 1'b0 || dp.err !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: done=%b err=%b one cycle later, expected 0 0", dp.done, dp.err);
        end
    endtask

    task automatic run(input logic ld, input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [31:0] data);
        issue(1'b0, ld, o, a, b, d, data);
        wait_done();
    endtask

    task automatic test_reset();
        clear = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (dp.ready !== 1'b1 || dp.done !== 1'b0 || dp.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b done=%b err=%b expected 1 0 0", dp.ready, dp.done, dp.err);
        end
        checks++;
        if (dp.bus !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h expected 0", dp.bus);
        end
        checks++;
        if (dp.hi !== 32'h0 || dp.lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: hi=%h lo=%h expected 0 0", dp.hi, dp.lo);
        end
        for (int i = 0; i < 16; i++) begin
            dp.dbg_sel = 4'(i);
            #1;
            checks++;
            if (dp.dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_R%0d: got %h expected 0", i, dp.dbg_data);
            end
        end
        model_reset();
        @(posedge clock);
        #1;
        clear = 1'b1;
    endtask

    task automatic test_load_add();
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd3, 32'h0000_0005);
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd4, 32'h0000_0007);
        issue(1'b0, 1'b0, 4'd0, 4'd3, 4'd4, 4'd5, 32'h0);
        @(negedge clock);
        checks++;
        if (dp.bus !== 32'h5) begin
            errors++;
            $display("FAIL bus_lda: got %h expected 00000005", dp.bus);
        end
        @(negedge clock);
        checks++;
        if (dp.bus !== 32'h7) begin
            errors++;
            $display("FAIL bus_exe: got %h expected 00000007", dp.bus);
        end
        @(negedge clock);
        checks++;
        if (dp.bus !== 32'hC) begin
            errors++;
            $display("FAIL bus_wbl: got %h expected 0000000c", dp.bus);
        end
        wait_done();
        checks++;
        if (dp.bus !== 32'h0) begin
            errors++;
            $display("FAIL bus_idle: got %h expected 0", dp.bus);
        end
    endtask

    task automatic test_alu_ops();
        run(1'b0, 4'd1, 4'd3, 4'd4, 4'd6, 32'h0);
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd3, 32'h0000_0001);
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd4, 32'd31);
        run(1'b0, 4'd5, 4'd3, 4'd4, 4'd8, 32'h0);
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd4, 32'd32);
        run(1'b0, 4'd6, 4'd3, 4'd4, 4'd9, 32'h0);
        for (int i = 0; i < 16; i++) begin
            run(1'b1, 4'd0, 4'd0, 4'd0, 4'd1, $urandom);
            run(1'b1, 4'd0, 4'd0, 4'd0, 4'd2, (i % 2 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
            run(1'b0, 4'(i % 8), 4'd1, 4'd2, 4'(9 + i % 3), 32'h0);
        end
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 32'h0000_0011);
        run(1'b0, 4'd0, 4'd1, 4'd1, 4'd1, 32'h0);
    endtask

    task automatic test_mul();
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd10, 32'h0000_0077);
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 32'hFFFF_FFFE);
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd2, 32'h0000_0003);
        run(1'b0, 4'd7, 4'd1, 4'd2, 4'd10, 32'h0);
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 32'h8000_0000);
        run(1'b0, 4'd7, 4'd1, 4'd1, 4'd0, 32'h0);
    endtask

    task automatic test_reserved_and_range();
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd2, 32'h0000_1234);
        run(1'b0, 4'd9, 4'd3, 4'd4, 4'd2, 32'h0);
        run(1'b0, 4'd15, 4'd1, 4'd1, 4'd3, 32'h0);
        run(1'b0, 4'd0, 4'd13, 4'd4, 4'd5, 32'h0);
        run(1'b0, 4'd0, 4'd3, 4'd4, 4'd14, 32'h0);
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd15, 32'hDEAD_BEEF);
        dp.dbg_sel = 4'd13;
        #1;
        checks++;
        if (dp.dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL dbg_out_of_range: got %h expected 0", dp.dbg_data);
        end
    endtask

    task automatic test_busy_start();
        run(1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 32'h0000_0042);
        issue(1'b0, 1'b0, 4'd0, 4'd3, 4'd4, 4'd0, 32'h0);
        @(posedge clock);
        #1;
        dp.cmd_load = 1'b1;
        dp.rd       = 4'd1;
        dp.din      = 32'hDEAD_0001;
        dp.start    = 1'b1;
        @(posedge clock);
        #1;
        dp.start = 1'b0;
        wait_done();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checks++;
            if (dp.done !== 1'b0) begin
                errors++;
                $display("FAIL busy_extra_done: done=%b %0d cycles after completion", dp.done, i + 2);
            end
        end
        dp.dbg_sel = 4'd1;
        #1;
        checks++;
        if (dp.dbg_data !== mdl[1]) begin
            errors++;
            $display("FAIL busy_R1: got %h expected %h", dp.dbg_data, mdl[1]);
        end
    endtask

    task automatic test_back_to_back();
        int first_done;
        @(posedge clock);
        #1;
        dp.cmd_load = 1'b0;
        dp.op       = 4'd0;
        dp.ra       = 4'd3;
        dp.rb       = 4'd4;
        dp.rd       = 4'd5;
        dp.start    = 1'b1;
        model_push(1'b0, 4'd0, 4'd3, 4'd4, 4'd5, 32'h0);
        @(posedge clock);
        #1;
        acc_q.push_back(cyc);
        dp.cmd_load = 1'b1;
        dp.rd       = 4'd11;
        dp.din      = 32'h0000_ABCD;
        model_push(1'b1, 4'd0, 4'd0, 4'd0, 4'd11, 32'h0000_ABCD);
        wait_done();
        first_done = last_done_cyc;
        acc_q.push_back(first_done + 1);
        @(posedge clock);
        #1;
        dp.start = 1'b0;
        wait_done();
        checks++;
        if (last_done_cyc - first_done != 2) begin
            errors++;
            $display("FAIL b2b_gap: second done %0d cycles after first, expected 2", last_done_cyc - first_done);
        end
    endtask

    task automatic test_mid_reset();
        issue(1'b0, 1'b0, 4'd0, 4'd3, 4'd4, 4'd7, 32'h0);
        @(posedge clock);
        #1;
        clear = 1'b0;
        #1;
        checks++;
        if (dp.ready !== 1'b1 || dp.done !== 1'b0 || dp.err !== 1'b0 || dp.bus !== 32'h0) begin
            errors++;
            $display("FAIL abort_outputs: ready=%b done=%b err=%b bus=%h expected 1 0 0 0",
                     dp.ready, dp.done, dp.err, dp.bus);
        end
        checks++;
        if (dp.hi !== 32'h0 || dp.lo !== 32'h0) begin
            errors++;
            $display("FAIL abort_hilo: hi=%h lo=%h expected 0 0", dp.hi, dp.lo);
        end
        dp.dbg_sel = 4'd7;
        #1;
        checks++;
        if (dp.dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_R7: got %h expected 0", dp.dbg_data);
        end
        dp.dbg_sel = 4'd3;
        #1;
        checks++;
        if (dp.dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_R3: got %h expected 0", dp.dbg_data);
        end
        model_reset();
        exp_q.delete();
        acc_q.delete();
        @(posedge clock);
        #1;
        clear = 1'b1;
        issue(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd7, 32'h0000_0055);
        wait_done();
    endtask

    initial begin
        clear       = 1'b0;
        dp.start    = 1'b0;
        dp.cmd_load = 1'b0;
        dp.op       = 4'd0;
        dp.ra       = 4'd0;
        dp.rb       = 4'd0;
        dp.rd       = 4'd0;
        dp.din      = 32'h0;
        dp.dbg_sel  = 4'd0;
        model_reset();

        test_reset();
        test_load_add();
        test_alu_ops();
        test_mul();
        test_reserved_and_range();
        test_busy_start();
        test_back_to_back();
        test_mid_reset();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected results never completed", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
